load_store_unit: RTL

- MEM-stage initiator for the word-addressed data memory: accepts load/store requests from the pipeline and drives the memory's address, write-data, write-enable and read-enable.
- Memory-side contract: combinational read, write committed on the rising clock edge.
- Adds RV32I byte/halfword support: lane extraction with sign/zero extension for loads, read-modify-write for SB/SH.
- Reports misaligned, out-of-range and illegal-width requests.
- Sits between the EX/MEM pipeline register and data memory; req_ready stalls the pipeline.

---
 rtl/load_store_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory.
// Adds RV32I byte/halfword lanes: sign/zero-extended loads and read-modify-write SB/SH.
module load_store_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [1:0]        resp_cause,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wd,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [31:0]       mem_data
);

  typedef enum logic [1:0] {StIdle, StLoad, StRmwRd, StWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              resp_valid_d, resp_err_d;
  logic [1:0]        resp_cause_d;
  logic [31:0]       resp_rdata_d;

  logic        accept, illegal, misaligned, out_of_range;
  logic [31:0] shifted, load_ext, store_data;

  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    if (req_we) begin
      illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
  end

  assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign out_of_range = |req_addr[31:ADDR_W+2];

  // Little-endian lane select: shift the addressed byte/halfword down to bit 0.
  assign shifted = mem_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = mem_data;
    endcase
  end

  always_comb begin
    store_data = merge_q;
    case (funct3_q[1:0])
      2'b00:   store_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_data = wdata_q;
    endcase
  end

  // Memory strobes decode straight from state so reset kills them immediately.
  assign req_ready    = (state_q == StIdle);
  assign mem_memread  = (state_q == StLoad) || (state_q == StRmwRd);
  assign mem_memwrite = (state_q == StWrite);
  assign mem_address  = (state_q != StIdle) ? addr_q[ADDR_W+1:2] : '0;
  assign mem_wd       = mem_memwrite ? store_data : 32'h0;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_cause_d = 2'b00;
    resp_rdata_d = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = req_addr[ADDR_W+1:0];
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          if (illegal || misaligned || out_of_range) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_cause_d = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b10);
          end else if (!req_we) begin
            state_d = StLoad;
          end else if (req_funct3 == 3'b010) begin
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
        state_d      = StIdle;
      end
      StRmwRd: begin
        merge_d = mem_data;
        state_d = StWrite;
      end
      StWrite: begin
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      funct3_q   <= 3'b000;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_cause <= 2'b00;
      resp_rdata <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_cause <= resp_cause_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule
